// File: rtl/ifetch_buf.sv
// Instruction fetch buffer: fetches two words per ROM access into a circular
// queue of {pc, word} entries. Optional stall statistic enabled by IFB_STAT_EN.
module ifetch_buf #(
  parameter int                 WIDTH    = 32,
  parameter int                 AWIDTH   = 30,
  parameter int                 DEPTH    = 4,
  parameter logic [AWIDTH-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              cs,
  output logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  dout_eve,
  input  logic [WIDTH-1:0]  dout_odd,
  output logic              inst_valid,
  output logic [WIDTH-1:0]  inst,
  output logic [AWIDTH-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [15:0]       stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FREE2_MAX = CW'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] fetch_pc;
  logic [CW-1:0]     count, count_next, count_after;
  logic [PW-1:0]     rd_ptr, wr_ptr, wr_ptr_1;
  logic              free_ok, push, pop;

  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [WIDTH-1:0]  word_mem [DEPTH];

  assign free_ok  = (count <= FREE2_MAX);
  assign push     = cs;
  assign pop      = inst_valid & inst_ready & ~redirect;
  assign wr_ptr_1 = wr_ptr + PW'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = count;
    if (push) count_next = count_next + CW'(2);
    if (pop)  count_next = count_next - CW'(1);
  end

  assign count_after = redirect ? '0 : count_next;

  // The state reflects run and the occupancy that the next cycle will see.
  always_comb begin
    state_next = IDLE;
    cs         = 1'b0;
    if (run) state_next = (count_after <= FREE2_MAX) ? FETCH : FULL;
    unique case (state)
      IDLE:    cs = run & ~redirect & free_ok;
      FETCH:   cs = run & ~redirect;
      FULL:    cs = 1'b0;
      default: cs = 1'b0;
    endcase
    if (rst) cs = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(2);
        fetch_pc <= fetch_pc + AWIDTH'(2);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: the entry storage has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]     <= fetch_pc;
      word_mem[wr_ptr]   <= dout_eve;
      pc_mem[wr_ptr_1]   <= fetch_pc + AWIDTH'(1);
      word_mem[wr_ptr_1] <= dout_odd;
    end
  end

  assign addr       = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? word_mem[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

`ifdef IFB_STAT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (run & ~free_ok & ~redirect & (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Self-checking bench for ifetch_buf: queue-based reference model compared every
// cycle, plus directed literal checks of the key fetch/redirect/reset scenarios.
module tb_ifetch_buf;

  localparam int AW    = 30;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic          clk, rst, run, redirect, cs, inst_valid, inst_ready;
  logic [AW-1:0] redirect_pc, addr, inst_pc;
  logic [W-1:0]  dout_eve, dout_odd, inst;
  logic [15:0]   stall_cnt;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  ifetch_buf #(.WIDTH(W), .AWIDTH(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
    .cs(cs), .addr(addr), .dout_eve(dout_eve), .dout_odd(dout_odd),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: mem[i] = i
  function automatic logic [W-1:0] rom(input logic [AW-1:0] a);
    return {2'b00, a};
  endfunction

  assign dout_eve = rom(addr);
  assign dout_odd = rom(addr + 30'd1);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a queue of {pc, word} and a fetch address.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [W-1:0]  w;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  int unsigned   m_stall;

  always @(posedge clk or posedge rst) begin : model
    bit do_push;
    if (rst) begin
      mq.delete();
      m_pc    = '0;
      m_stall = 0;
    end else begin
      do_push = run && !redirect && ((DEPTH - mq.size()) >= 2);
`ifdef IFB_STAT_EN
      if (run && !redirect && ((DEPTH - mq.size()) < 2) && m_stall < 16'hFFFF) m_stall++;
`endif
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc;
      end else begin
        if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back('{pc: m_pc, w: rom(m_pc)});
          mq.push_back('{pc: m_pc + 30'd1, w: rom(m_pc + 30'd1)});
          m_pc = m_pc + 30'd2;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      logic exp_cs;
      exp_cs = !rst && run && !redirect && ((DEPTH - mq.size()) >= 2);
      check("m_cs", cs, exp_cs);
      check("m_addr", addr, m_pc);
      check("m_valid", inst_valid, mq.size() != 0);
      check("m_inst", inst, (mq.size() != 0) ? mq[0].w : '0);
      check("m_inst_pc", inst_pc, (mq.size() != 0) ? mq[0].pc : '0);
      check("m_stall", stall_cnt, m_stall);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] s0;
    int          exp_d;
    rst = 1'b1; run = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Reset state
    #3;
    check("rst_cs", cs, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_addr", addr, 0);
    check("rst_stall", stall_cnt, 0);

    // Streaming from RESET_PC with the consumer always ready
    @(negedge clk); #1;
    rst = 1'b0; run = 1'b1; inst_ready = 1'b1; chk_en = 1'b1;
    #1;
    check("first_cs", cs, 1);
    check("first_addr", addr, 0);
    check("first_valid", inst_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_inst", inst, i);
      check("stream_pc", inst_pc, i);
      if (i == 1) check("count3_no_push", cs, 0);
      if (i == 2) begin
        check("count2_push", cs, 1);
        check("count2_addr", addr, 4);
      end
    end

    // Redirect while three entries are buffered
    #1; redirect = 1'b1; redirect_pc = 30'h100;
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk);
    check("redir_valid", inst_valid, 0);
    check("redir_cs", cs, 1);
    check("redir_addr", addr, 30'h100);
    @(negedge clk);
    check("redir_inst", inst, 32'h100);
    check("redir_inst_pc", inst_pc, 30'h100);

    // Address wrap at the top of the space; consumer stalled fills the buffer
    #1; redirect = 1'b1; redirect_pc = 30'h3FFFFFFE; inst_ready = 1'b0;
    @(posedge clk); #1; redirect = 1'b0;
    @(negedge clk);
    check("wrap_cs", cs, 1);
    check("wrap_addr", addr, 30'h3FFFFFFE);
    @(negedge clk);
    check("wrap_inst_pc", inst_pc, 30'h3FFFFFFE);
    check("wrap_inst", inst, 32'h3FFFFFFE);
    check("wrap_next_addr", addr, 0);
    check("wrap_cs2", cs, 1);
    @(negedge clk);
    check("full_cs", cs, 0);
    check("full_head", inst_pc, 30'h3FFFFFFE);
    s0 = stall_cnt;
    repeat (3) @(negedge clk);
`ifdef IFB_STAT_EN
    exp_d = 3;
`else
    exp_d = 0;
`endif
    check("stall_incr", 64'(stall_cnt - s0), exp_d);
    check("full_cs_hold", cs, 0);

    // Single pop leaves count=3: no new fetch
    #1; inst_ready = 1'b1;
    @(posedge clk); #1; inst_ready = 1'b0;
    @(negedge clk);
    check("pop_head", inst_pc, 30'h3FFFFFFF);
    check("pop_cs", cs, 0);

    // run drops: no fetch, buffered entries drain
    #1; run = 1'b0;
    @(negedge clk);
    check("norun_cs", cs, 0);
    check("norun_valid", inst_valid, 1);
    #1; inst_ready = 1'b1;
    @(negedge clk);
    check("drain_pc0", inst_pc, 0);
    @(negedge clk);
    check("drain_pc1", inst_pc, 1);
    @(negedge clk);
    check("drain_empty", inst_valid, 0);
    check("drain_cs", cs, 0);

    // Asynchronous reset mid-stream
    #1; run = 1'b1;
    repeat (3) @(negedge clk);
    #2; rst = 1'b1;
    #1;
    check("arst_cs", cs, 0);
    check("arst_valid", inst_valid, 0);
    check("arst_inst", inst, 0);
    check("arst_inst_pc", inst_pc, 0);
    check("arst_addr", addr, 0);
    check("arst_stall", stall_cnt, 0);
    @(negedge clk); #1; rst = 1'b0;
    #1;
    check("rel_cs", cs, 1);
    check("rel_addr", addr, 0);
    @(negedge clk);
    check("rel_valid", inst_valid, 1);
    check("rel_inst_pc", inst_pc, 0);
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_buf.md
IFETCH_BUF -- requirements
Module: ifetch_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32: instruction word width.
REQ-002 SHALL have parameter AWIDTH, default 30: word address width.
REQ-003 SHALL have parameter DEPTH, default 4: buffer entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0: fetch word address after reset.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port run  input  1  fetch enable.
REQ-008 SHALL have port redirect  input  1  flushes the buffer and restarts fetch.
REQ-009 SHALL have port redirect_pc  input  AWIDTH  restart word address.
REQ-010 SHALL have port cs  output  1  ROM select.
REQ-011 SHALL have port addr  output  AWIDTH  ROM word address (= fetch_pc).
REQ-012 SHALL have port dout_eve  input  WIDTH  ROM word at addr; combinational, same cycle.
REQ-013 SHALL have port dout_odd  input  WIDTH  ROM word at addr+1; combinational, same cycle.
REQ-014 SHALL have port inst_valid  output  1  buffer head is valid.
REQ-015 SHALL have port inst  output  WIDTH  head instruction; 0 when empty.
REQ-016 SHALL have port inst_pc  output  AWIDTH  head word address; 0 when empty.
REQ-017 SHALL have port inst_ready  input  1  consumer accepts the head.
REQ-018 SHALL have port stall_cnt  output  16  full-stall statistic (see Configuration).

Function
REQ-019 SHALL hold internal fetch_pc, count (0..DEPTH), and circular rd/wr pointers; each entry stores {pc, word}.
REQ-020 SHALL use a state machine with states IDLE (run=0), FETCH (run=1, free>=2), FULL (run=1, free<2), where free = DEPTH-count from the registered count.
REQ-021 SHALL drive cs = run & ~redirect & (free>=2), combinationally; addr = fetch_pc at all times.
REQ-022 SHALL, on an edge with cs=1, push {fetch_pc, dout_eve} then {fetch_pc+1, dout_odd} (two entries, eve first) and set fetch_pc += 2.
REQ-023 SHALL pop one entry on an edge with inst_valid & inst_ready; inst_valid = (count != 0).
REQ-024 SHALL allow a push and a pop on the same edge: count_next = count + 2 - 1.
REQ-025 SHALL compute fetch_pc and entry pc modulo 2^AWIDTH: max address wraps to 0, and pointers wrap modulo DEPTH.
REQ-026 SHALL, on an edge with redirect=1, set count=0, pointers=0, fetch_pc=redirect_pc, with no push; any pop in that cycle is discarded, and redirect has priority over push and pop.
REQ-027 SHALL give redirect-to-first-instruction latency: cs=1 with addr=redirect_pc in the cycle after the redirect edge, and inst_valid=1 in the cycle after that.
REQ-028 SHALL, when run drops, complete nothing further: no pending access exists beyond the current cycle, and buffered entries remain poppable.

Reset
REQ-029 SHALL, while rst=1 regardless of clk, force fetch_pc=RESET_PC, count=0, pointers=0, state=IDLE, cs=0, inst_valid=0, inst=0, inst_pc=0, stall_cnt=0.
REQ-030 SHALL treat rst as overriding redirect, push and pop; the first fetch after release is at RESET_PC if run=1.

Configuration
REQ-031 SHALL, with IFB_STAT_EN defined, count in stall_cnt the edges with state FULL and redirect=0, saturating at 16'hFFFF and cleared only by rst.
REQ-032 SHALL, with IFB_STAT_EN undefined, tie stall_cnt to 0, keep the port present, and omit the counter logic.

Verification
REQ-033 SHALL cover: rst release, run=1, RESET_PC=0, ROM mem[i]=i, inst_ready=1 -> addr 0,2,4..., inst stream 0,1,2,3... with inst_pc==inst.
REQ-034 SHALL cover: inst_ready=0, DEPTH=4 -> two fetches (count=4), then cs=0 in state FULL; with IFB_STAT_EN, stall_cnt increments 1 per cycle.
REQ-035 SHALL cover: redirect with redirect_pc=0x100 while buffer holds 3 entries and inst_ready=1 -> next cycle inst_valid=0, cs=1, addr=0x100; following cycle inst=mem[0x100], inst_pc=0x100.
REQ-036 SHALL cover: redirect_pc=2^AWIDTH-2 -> entries pc 0x3FFFFFFE, 0x3FFFFFFF, then next addr=0.
REQ-037 SHALL cover: rst asserted mid-stream between edges -> outputs zero immediately, fetch_pc=RESET_PC, count=0.
REQ-038 SHALL cover: count=3, DEPTH=4, inst_ready=1 -> no push (free=1), pop to 2, push next edge to 3.
